// File: rtl/intersection_controller.sv
// Two-road signalised intersection sequencer. Produces the one-hot road
// lights, the per-phase tick countdown for the pedestrian lights, and the
// crosswalk enables, with pedestrian requests latched until the matching
// green starts.
module intersection_controller #(
    parameter int TICK_DIV     = 50,
    parameter int GREEN_TIME   = 60,
    parameter int YELLOW_TIME  = 4,
    parameter int ALL_RED_TIME = 2,
    parameter int PED_MIN_TIME = 90
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [6:0] master_timer,
    output logic       ped_enable_ns,
    output logic       ped_enable_ew,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        RED_A     = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        RED_B     = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5
    } state_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam logic [6:0] GREEN_D   = 7'(GREEN_TIME);
    localparam logic [6:0] YELLOW_D  = 7'(YELLOW_TIME);
    localparam logic [6:0] ALL_RED_D = 7'(ALL_RED_TIME);
    localparam logic [6:0] PED_D     = 7'(PED_MIN_TIME);
    // A served pedestrian never shortens the green, only lengthens it.
    localparam logic [6:0] PED_GREEN_D = (PED_D > GREEN_D) ? PED_D : GREEN_D;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    state_t        state_r, state_s;
    logic [6:0]    timer_r, timer_s;
    logic [2:0]    ns_light_r, ns_light_s;
    logic [2:0]    ew_light_r, ew_light_s;
    logic          en_ns_r, en_ns_s;
    logic          en_ew_r, en_ew_s;
    logic          req_ns_r, req_ns_s;
    logic          req_ew_r, req_ew_s;
    logic [PW-1:0] presc_r;
    logic          tick_s;
    logic          serve_ns_s;
    logic          serve_ew_s;

    assign tick_s     = (presc_r == PRESC_LAST);
    // A press in the very clk of green entry is served rather than latched.
    assign serve_ns_s = req_ns_r | ped_req_ns;
    assign serve_ew_s = req_ew_r | ped_req_ew;

    // Free-running 1-second prescaler, independent of phase changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Phase sequencing, countdown, request latching and crosswalk enables.
    always_comb begin
        state_s  = state_r;
        timer_s  = timer_r;
        en_ns_s  = en_ns_r;
        en_ew_s  = en_ew_r;
        req_ns_s = serve_ns_s;
        req_ew_s = serve_ew_s;
        if (state_r > EW_YELLOW) begin
            // Corrupted encoding: fall back to the all-red clearance.
            state_s = RED_A;
            timer_s = ALL_RED_D;
            en_ns_s = 1'b0;
            en_ew_s = 1'b0;
        end else if (tick_s && (timer_r > 7'd1)) begin
            timer_s = timer_r - 7'd1;
        end else if (tick_s) begin
            case (state_r)
                RED_A: begin
                    state_s  = NS_GREEN;
                    timer_s  = serve_ns_s ? PED_GREEN_D : GREEN_D;
                    en_ns_s  = serve_ns_s;
                    req_ns_s = 1'b0;
                end
                NS_GREEN: begin
                    state_s = NS_YELLOW;
                    timer_s = YELLOW_D;
                    en_ns_s = 1'b0;
                end
                NS_YELLOW: begin
                    state_s = RED_B;
                    timer_s = ALL_RED_D;
                end
                RED_B: begin
                    state_s  = EW_GREEN;
                    timer_s  = serve_ew_s ? PED_GREEN_D : GREEN_D;
                    en_ew_s  = serve_ew_s;
                    req_ew_s = 1'b0;
                end
                EW_GREEN: begin
                    state_s = EW_YELLOW;
                    timer_s = YELLOW_D;
                    en_ew_s = 1'b0;
                end
                EW_YELLOW: begin
                    state_s = RED_A;
                    timer_s = ALL_RED_D;
                end
                default: begin
                    state_s = RED_A;
                    timer_s = ALL_RED_D;
                    en_ns_s = 1'b0;
                    en_ew_s = 1'b0;
                end
            endcase
        end else begin
            timer_s = timer_r;
        end
    end

    // Light decode from the upcoming state so lights and phase update together.
    always_comb begin
        ns_light_s = LIGHT_RED;
        ew_light_s = LIGHT_RED;
        case (state_s)
            NS_GREEN:  ns_light_s = LIGHT_GREEN;
            NS_YELLOW: ns_light_s = LIGHT_YELLOW;
            EW_GREEN:  ew_light_s = LIGHT_GREEN;
            EW_YELLOW: ew_light_s = LIGHT_YELLOW;
            default: begin
                ns_light_s = LIGHT_RED;
                ew_light_s = LIGHT_RED;
            end
        endcase
    end

    // State and output registers; reset forces the safe all-red state at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= RED_A;
            timer_r    <= ALL_RED_D;
            ns_light_r <= LIGHT_RED;
            ew_light_r <= LIGHT_RED;
            en_ns_r    <= 1'b0;
            en_ew_r    <= 1'b0;
            req_ns_r   <= 1'b0;
            req_ew_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            ns_light_r <= ns_light_s;
            ew_light_r <= ew_light_s;
            en_ns_r    <= en_ns_s;
            en_ew_r    <= en_ew_s;
            req_ns_r   <= req_ns_s;
            req_ew_r   <= req_ew_s;
        end
    end

    assign ns_light      = ns_light_r;
    assign ew_light      = ew_light_r;
    assign master_timer  = timer_r;
    assign ped_enable_ns = en_ns_r;
    assign ped_enable_ew = en_ew_r;
    assign phase         = state_r;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller with a short tick so whole
// light cycles fit in a few hundred clocks. Outputs are sampled on the
// falling edge; "edge N" below means N rising edges after reset release.
module tb_intersection_controller;

    logic       clk;
    logic       reset_n;
    logic       ped_req_ns;
    logic       ped_req_ew;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [6:0] master_timer;
    logic       ped_enable_ns;
    logic       ped_enable_ew;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    intersection_controller #(
        .TICK_DIV(4), .GREEN_TIME(6), .YELLOW_TIME(3),
        .ALL_RED_TIME(2), .PED_MIN_TIME(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
        .ns_light(ns_light), .ew_light(ew_light),
        .master_timer(master_timer),
        .ped_enable_ns(ped_enable_ns), .ped_enable_ew(ped_enable_ew),
        .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic advance(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset for two clks and release on a falling edge (edge count 0).
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase: got %0d want 0", phase); end
        checks++; if (master_timer !== 7'd2) begin errors++; $display("FAIL reset_timer: got %0d want 2", master_timer); end
        checks++; if (ns_light !== 3'b100 || ew_light !== 3'b100) begin errors++; $display("FAIL reset_lights: got %b/%b want 100/100", ns_light, ew_light); end
        checks++; if (ped_enable_ns !== 1'b0 || ped_enable_ew !== 1'b0) begin errors++; $display("FAIL reset_enables: got %b%b want 00", ped_enable_ns, ped_enable_ew); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Full cycle with no requests: each timer value held for 4 clks.
    task automatic test_normal_cycle();
        int         dur_t [6] = '{2, 6, 3, 2, 6, 3};
        logic [2:0] ns_t  [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
        logic [2:0] ew_t  [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
        do_reset();
        for (int p = 0; p < 6; p++) begin
            for (int v = dur_t[p]; v >= 1; v--) begin
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if (phase !== 3'(p) || master_timer !== 7'(v) || ns_light !== ns_t[p] ||
                        ew_light !== ew_t[p] || ped_enable_ns !== 1'b0 || ped_enable_ew !== 1'b0) begin
                        errors++;
                        $display("FAIL normal_cycle: got ph=%0d t=%0d ns=%b ew=%b en=%b%b want ph=%0d t=%0d ns=%b ew=%b en=00",
                                 phase, master_timer, ns_light, ew_light, ped_enable_ns, ped_enable_ew, p, v, ns_t[p], ew_t[p]);
                    end
                    advance(1);
                end
            end
        end
        checks++; if (phase !== 3'd0 || master_timer !== 7'd2) begin errors++; $display("FAIL normal_wrap: got ph=%0d t=%0d want ph=0 t=2", phase, master_timer); end
    endtask

    // One-clk NS press during RED_B lengthens the next NS green to 8 ticks.
    task automatic test_ped_ns_pulse();
        int cnt;
        do_reset();
        advance(46);                       // edge 46, inside RED_B
        checks++; if (phase !== 3'd3) begin errors++; $display("FAIL pulse_in_red_b: got ph=%0d want 3", phase); end
        ped_req_ns = 1'b1;
        advance(1);
        ped_req_ns = 1'b0;
        advance(49);                       // edge 96: NS green entry
        checks++; if (phase !== 3'd1 || master_timer !== 7'd8 || ped_enable_ns !== 1'b1) begin errors++; $display("FAIL pulse_ns_entry: got ph=%0d t=%0d en=%b want ph=1 t=8 en=1", phase, master_timer, ped_enable_ns); end
        cnt = 0;
        while (ped_enable_ns === 1'b1 && cnt < 40) begin
            cnt++;
            advance(1);
        end
        checks++; if (cnt !== 32) begin errors++; $display("FAIL pulse_ns_enable_len: got %0d clks want 32", cnt); end
        checks++; if (ns_light !== 3'b010 || ped_enable_ns !== 1'b0) begin errors++; $display("FAIL pulse_ns_exit: got ns=%b en=%b want 010 0", ns_light, ped_enable_ns); end
        advance(64);                       // edge 192: following NS green
        checks++; if (phase !== 3'd1 || master_timer !== 7'd6 || ped_enable_ns !== 1'b0) begin errors++; $display("FAIL pulse_ns_next: got ph=%0d t=%0d en=%b want ph=1 t=6 en=0", phase, master_timer, ped_enable_ns); end
    endtask

    // EW press exactly in the clk of EW green entry is served immediately.
    task automatic test_ped_ew_entry();
        do_reset();
        advance(51);
        ped_req_ew = 1'b1;
        advance(1);                        // edge 52: EW green entry
        ped_req_ew = 1'b0;
        checks++; if (phase !== 3'd4 || master_timer !== 7'd8 || ped_enable_ew !== 1'b1 || ew_light !== 3'b001) begin errors++; $display("FAIL ew_entry: got ph=%0d t=%0d en=%b ew=%b want ph=4 t=8 en=1 ew=001", phase, master_timer, ped_enable_ew, ew_light); end
        checks++; if (ped_enable_ns !== 1'b0 || ns_light !== 3'b100) begin errors++; $display("FAIL ew_entry_ns_side: got en=%b ns=%b want 0 100", ped_enable_ns, ns_light); end
        advance(96);                       // edge 148: next EW green
        checks++; if (phase !== 3'd4 || master_timer !== 7'd6 || ped_enable_ew !== 1'b0) begin errors++; $display("FAIL ew_next: got ph=%0d t=%0d en=%b want ph=4 t=6 en=0", phase, master_timer, ped_enable_ew); end
    endtask

    // NS button held: every NS green served, EW untouched.
    task automatic test_ped_ns_held();
        do_reset();
        ped_req_ns = 1'b1;
        advance(8);
        checks++; if (phase !== 3'd1 || master_timer !== 7'd8 || ped_enable_ns !== 1'b1) begin errors++; $display("FAIL held_ns_first: got ph=%0d t=%0d en=%b want ph=1 t=8 en=1", phase, master_timer, ped_enable_ns); end
        advance(31);
        checks++; if (ped_enable_ns !== 1'b1 || master_timer !== 7'd1) begin errors++; $display("FAIL held_ns_last: got en=%b t=%0d want en=1 t=1", ped_enable_ns, master_timer); end
        advance(1);
        checks++; if (ped_enable_ns !== 1'b0 || ns_light !== 3'b010) begin errors++; $display("FAIL held_ns_exit: got en=%b ns=%b want 0 010", ped_enable_ns, ns_light); end
        advance(20);
        checks++; if (phase !== 3'd4 || master_timer !== 7'd6 || ped_enable_ew !== 1'b0) begin errors++; $display("FAIL held_ew: got ph=%0d t=%0d en=%b want ph=4 t=6 en=0", phase, master_timer, ped_enable_ew); end
        advance(44);
        checks++; if (phase !== 3'd1 || master_timer !== 7'd8 || ped_enable_ns !== 1'b1) begin errors++; $display("FAIL held_ns_second: got ph=%0d t=%0d en=%b want ph=1 t=8 en=1", phase, master_timer, ped_enable_ns); end
        ped_req_ns = 1'b0;
    endtask

    // Asynchronous reset mid green also discards a pending request.
    task automatic test_reset_mid();
        do_reset();
        ped_req_ns = 1'b1;
        advance(1);
        ped_req_ns = 1'b0;
        advance(19);                       // edge 20, NS green
        ped_req_ns = 1'b1;
        advance(1);
        ped_req_ns = 1'b0;
        advance(4);                        // edge 25
        checks++; if (master_timer !== 7'd4 || ped_enable_ns !== 1'b1 || phase !== 3'd1) begin errors++; $display("FAIL mid_before: got ph=%0d t=%0d en=%b want ph=1 t=4 en=1", phase, master_timer, ped_enable_ns); end
        reset_n = 1'b0;
        #1;
        checks++; if (phase !== 3'd0 || master_timer !== 7'd2) begin errors++; $display("FAIL mid_async_state: got ph=%0d t=%0d want ph=0 t=2", phase, master_timer); end
        checks++; if (ns_light !== 3'b100 || ew_light !== 3'b100 || ped_enable_ns !== 1'b0 || ped_enable_ew !== 1'b0) begin errors++; $display("FAIL mid_async_outputs: got %b/%b en=%b%b want 100/100 en=00", ns_light, ew_light, ped_enable_ns, ped_enable_ew); end
        @(negedge clk);
        reset_n = 1'b1;
        advance(4);
        checks++; if (phase !== 3'd0 || master_timer !== 7'd1) begin errors++; $display("FAIL mid_restart_red: got ph=%0d t=%0d want ph=0 t=1", phase, master_timer); end
        advance(4);
        checks++; if (phase !== 3'd1 || master_timer !== 7'd6 || ped_enable_ns !== 1'b0) begin errors++; $display("FAIL mid_restart_green: got ph=%0d t=%0d en=%b want ph=1 t=6 en=0", phase, master_timer, ped_enable_ns); end
    endtask

    // 1000 ticks of random presses: invariant checks every clk.
    task automatic test_safety();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            ped_req_ns = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
            ped_req_ew = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
            advance(1);
            checks++; if ($onehot(ns_light) !== 1'b1 || $onehot(ew_light) !== 1'b1) begin errors++; $display("FAIL safety_onehot: got %b/%b", ns_light, ew_light); end
            checks++; if (ns_light !== 3'b100 && ew_light !== 3'b100) begin errors++; $display("FAIL safety_conflict: got %b/%b want one road 100", ns_light, ew_light); end
            checks++; if (master_timer < 7'd1 || master_timer > 7'd8) begin errors++; $display("FAIL safety_timer: got %0d want 1..8", master_timer); end
            checks++; if ((ped_enable_ns === 1'b1 && phase !== 3'd1) || (ped_enable_ew === 1'b1 && phase !== 3'd4)) begin errors++; $display("FAIL safety_enable: got en=%b%b ph=%0d", ped_enable_ns, ped_enable_ew, phase); end
        end
        ped_req_ns = 1'b0;
        ped_req_ew = 1'b0;
    endtask

    initial begin
        ped_req_ns = 1'b0;
        ped_req_ew = 1'b0;
        test_reset();
        test_normal_cycle();
        test_ped_ns_pulse();
        test_ped_ew_entry();
        test_ped_ns_held();
        test_reset_mid();
        test_safety();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intersection_controller.md
Name: intersection_controller

Overview:
- Sequences a two-road signalised intersection (north-south and east-west).
- Generates the 7-bit per-phase countdown (`master_timer`) and the per-crosswalk `enable` that drive two `pedestrian_light` instances.
- Latches pedestrian push-button requests and grants a walk phase concurrent with the matching road's green.
- Lengthens that green to a pedestrian minimum when required.

Parameters:
- TICK_DIV, 50, clk cycles per 1-second tick (>=2).
- GREEN_TIME, 60, green duration in ticks (1..127).
- YELLOW_TIME, 4, yellow duration in ticks (1..127).
- ALL_RED_TIME, 2, all-red clearance duration in ticks (1..127).
- PED_MIN_TIME, 90, minimum green when a pedestrian is served (1..127).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- ped_req_ns  input  1  NS crosswalk button, level or pulse, sampled every clk
- ped_req_ew  input  1  EW crosswalk button, level or pulse, sampled every clk
- ns_light  output  3  {red, yellow, green}, one-hot
- ew_light  output  3  {red, yellow, green}, one-hot
- master_timer  output  7  ticks remaining in current phase, to pedestrian_light
- ped_enable_ns  output  1  enable for NS pedestrian_light
- ped_enable_ew  output  1  enable for EW pedestrian_light
- phase  output  3  current state encoding, for debug

Behaviour:
- States and `phase` encodings:
  - RED_A = 0: all red, before NS
  - NS_GREEN = 1
  - NS_YELLOW = 2
  - RED_B = 3: all red, before EW
  - EW_GREEN = 4
  - EW_YELLOW = 5
  - Encodings 6 and 7 are illegal and go to RED_A on the next clk.
- Cycle order: RED_A -> NS_GREEN -> NS_YELLOW -> RED_B -> EW_GREEN -> EW_YELLOW -> RED_A.
- Reset (async assert, sync release):
  - phase = RED_A; master_timer = ALL_RED_TIME.
  - ns_light = ew_light = 3'b100.
  - ped_enable_* = 0; request latches cleared; prescaler = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - `tick` is high for one clk when count == TICK_DIV-1.
  - The prescaler is never reset by phase changes.
- On tick:
  - If master_timer > 1: decrement by 1.
  - If master_timer == 1: advance to the next state and load its duration in the same clk.
  - master_timer never shows 0 outside of illegal recovery; it counts duration down to 1.
- Durations by state:
  - RED_A, RED_B: ALL_RED_TIME.
  - Yellows: YELLOW_TIME.
  - Greens: GREEN_TIME, or max(GREEN_TIME, PED_MIN_TIME) when that road's request latch is set at green entry. Compare as 7-bit unsigned.
- Lights are registered and change in the same clk as `phase`:
  - Green state: that road = 001, other road = 100.
  - Yellow state: that road = 010, other road = 100.
  - RED states: both roads = 100.
  - The NS and EW roads are never both non-red.
- Request latches:
  - `req_ns_q` is set by ped_req_ns = 1 on any clk.
  - On the clk entering NS_GREEN: ped_enable_ns <= req_ns_q (or ped_req_ns in that same clk), and req_ns_q is cleared.
  - Clear has priority over set only for the request that is being served. A request arriving in the entry clk is served, not re-latched.
  - Requests arriving during NS_GREEN or later latch for the next cycle.
  - EW behaves the same way with EW_GREEN.
- ped_enable_ns stays high for the whole of NS_GREEN and deasserts on the clk leaving NS_GREEN. It is never high in yellow or red. EW behaves the same way.
- Reset asserted mid-phase immediately forces the reset values listed above, including the lights to red.
- Latency:
  - A button press is visible in the enable at the next green entry of that road.
  - Phase change to output change is 0 extra clks (registered together).

Test Plan (TICK_DIV=4, GREEN_TIME=6, YELLOW_TIME=3, ALL_RED_TIME=2, PED_MIN_TIME=8):
- Reset released, no requests:
  - master_timer reads 2,1 (RED_A), then 6..1 (NS_GREEN, ns_light=001), then 3..1 (NS_YELLOW, 010), 2..1 (RED_B), 6..1 (EW_GREEN, ew_light=001), 3..1 (EW_YELLOW).
  - Each value is held 4 clks; ped enables stay 0.
- One-clk ped_req_ns pulse during RED_B:
  - Next NS_GREEN loads 8.
  - ped_enable_ns = 1 for exactly 32 clks, then 0 in the same clk ns_light becomes 010.
  - The following NS_GREEN loads 6 with enable 0.
- ped_req_ew pulse in the exact clk of EW_GREEN entry:
  - That green has ped_enable_ew = 1 and master_timer = 8.
  - The latch is clear afterwards, so the next EW green is 6.
- ped_req_ns held high continuously:
  - Every NS_GREEN has enable = 1 and duration 8.
  - EW is unaffected (duration 6, enable 0).
- reset_n pulsed low mid-NS_GREEN at master_timer = 4:
  - Outputs go to phase = 0, lights 100/100, master_timer = 2, enables 0, asynchronously without waiting for a clk.
  - After release the sequence restarts as in scenario 1.
- Safety check over 1000 ticks of random requests:
  - ns_light and ew_light are never both non-100.
  - Each light is always one-hot.
  - master_timer is always in 1..8.
